// File: rtl/rreg_mux_n.sv
// Registered priority read-register mux: live output while idle, frozen capture per read strobe.
// Optional multi-select detection is built when RREG_MUX_CONFLICT_EN is defined.
module rreg_mux_n #(
  parameter int unsigned         WIDTH      = 8,
  parameter int unsigned         CHANNELS   = 4,
  parameter logic [WIDTH-1:0]    IDLE_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       sel,
  input  logic [CHANNELS*WIDTH-1:0] data,
  input  logic                      rd,
  output logic [WIDTH-1:0]          o,
  output logic                      o_valid,
  output logic [CHANNELS-1:0]       rd_ack,
  output logic                      conflict,
  output logic [7:0]                conflict_count
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic                rd_q;
  logic                rd_rise;
  logic [WIDTH-1:0]    o_q, o_d, mux_val;
  logic                valid_q, valid_d;
  logic [CHANNELS-1:0] ack_q, ack_d, win_oh;
  logic                hit;

  assign rd_rise = rd & ~rd_q;

  // Upward scan with a found flag so the lowest set index wins.
  always_comb begin
    mux_val = IDLE_VALUE;
    win_oh  = '0;
    hit     = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (sel[i] && !hit) begin
        hit       = 1'b1;
        mux_val   = data[i*WIDTH +: WIDTH];
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    valid_d = valid_q;
    ack_d   = '0;
    case (state_q)
      S_IDLE: begin
        o_d     = mux_val;
        valid_d = 1'b0;
        if (rd_rise) begin
          state_d = S_HOLD;
          valid_d = 1'b1;
          ack_d   = win_oh;
        end
      end
      S_HOLD: begin
        if (!rd) begin
          state_d = S_IDLE;
          o_d     = mux_val;
          valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rd_q resets high so a strobe held through reset release is not taken as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b1;
      o_q     <= IDLE_VALUE;
      valid_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd;
      o_q     <= o_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end

  assign o       = o_q;
  assign o_valid = valid_q;
  assign rd_ack  = ack_q;

`ifdef RREG_MUX_CONFLICT_EN
  logic       capture;
  logic       multi_sel;
  logic       conflict_q;
  logic [7:0] count_q;

  assign capture   = (state_q == S_IDLE) && rd_rise;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_sel = |(sel & (sel - CHANNELS'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q <= 1'b0;
      count_q    <= '0;
    end else if (capture && multi_sel) begin
      conflict_q <= 1'b1;
      if (count_q != 8'hFF) count_q <= count_q + 8'd1;
    end
  end

  assign conflict       = conflict_q;
  assign conflict_count = count_q;
`else
  assign conflict       = 1'b0;
  assign conflict_count = '0;
`endif

endmodule
